// File: rtl/regbank_sb.sv
// Parametrised multi-read/one-write register bank with a per-register pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGBANK_BYPASS_EN.
module regbank_sb #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        reg_wr,
    input  logic [DATA_W-1:0]        data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_reg,
    input  logic [NUM_RD*ADDR_W-1:0] rd_reg,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend_reg;
    logic [DEPTH-1:0]  pend_next;
    logic [CNT_W-1:0]  pend_cnt_reg;
    logic [CNT_W-1:0]  pend_cnt_next;
    logic              wr_ok;
    logic              iss_ok;

    // Register 0 is hard-wired when ZERO_REG is set, so its writes and issues are filtered here once.
    assign wr_ok  = write_en && !((ZERO_REG != 0) && (reg_wr == '0));
    assign iss_ok = issue_en && !((ZERO_REG != 0) && (issue_reg == '0));

    // Issue wins over a completing write: the new producer supersedes the old one.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            assign pend_next[gi] = (iss_ok && (issue_reg == ADDR_W'(gi))) ? 1'b1 :
                                   (wr_ok  && (reg_wr    == ADDR_W'(gi))) ? 1'b0 :
                                   pend_reg[gi];
        end
    endgenerate

    always_comb begin
        pend_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_next = pend_cnt_next + CNT_W'(pend_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[reg_wr] <= data;
        end
    end

    // Count is registered from the same next-state vector, so it always matches pend_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg     <= '0;
            pend_cnt_reg <= '0;
        end else begin
            pend_reg     <= pend_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] idx;
            logic              zero_hit;

            assign idx      = rd_reg[gi*ADDR_W +: ADDR_W];
            assign zero_hit = (ZERO_REG != 0) && (idx == '0);

`ifdef REGBANK_BYPASS_EN
            logic byp_hit;

            // Forwarding the in-flight writeback; busy survives only if a new producer targets it now.
            assign byp_hit = wr_ok && (reg_wr == idx);
            assign rd_data[gi*DATA_W +: DATA_W] = zero_hit ? '0 :
                                                  byp_hit  ? data : regs[idx];
            assign rd_busy[gi] = zero_hit ? 1'b0 :
                                 byp_hit  ? (iss_ok && (issue_reg == idx)) : pend_reg[idx];
`else
            assign rd_data[gi*DATA_W +: DATA_W] = zero_hit ? '0 : regs[idx];
            assign rd_busy[gi] = zero_hit ? 1'b0 : pend_reg[idx];
`endif
        end
    endgenerate

    assign any_busy = |rd_busy;
    assign pend_cnt = pend_cnt_reg;

endmodule

// File: tb/tb_regbank_sb.sv
// Self-checking bench for regbank_sb: directed test-plan steps plus randomized traffic
// checked every cycle against a behavioural array/scoreboard model.
module tb_regbank_sb;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             write_en;
    logic [AW-1:0]    reg_wr;
    logic [DW-1:0]    data;
    logic             issue_en;
    logic [AW-1:0]    issue_reg;
    logic [NR*AW-1:0] rd_reg;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             any_busy;
    logic [AW:0]      pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [DW-1:0] m_regs [DP];
    bit            m_pend [DP];
    bit            model_valid = 0;

    regbank_sb #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .reg_wr(reg_wr), .data(data),
        .issue_en(issue_en), .issue_reg(issue_reg), .rd_reg(rd_reg), .rd_data(rd_data),
        .rd_busy(rd_busy), .any_busy(any_busy), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input int idx);
        rd_reg[k*AW +: AW] = AW'(idx);
    endtask

    task automatic idle();
        write_en = 0;
        issue_en = 0;
        reset    = 0;
    endtask

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        int idx;
        int cnt;
        logic [DW-1:0] ed;
        bit eb;
        bit anyb;
        if (model_valid) begin
            anyb = 0;
            for (int k = 0; k < NR; k++) begin
                idx = int'(rd_reg[k*AW +: AW]);
                if (idx == 0) begin
                    ed = '0;
                    eb = 0;
`ifdef REGBANK_BYPASS_EN
                end else if (write_en && int'(reg_wr) == idx) begin
                    ed = data;
                    eb = issue_en && int'(issue_reg) == idx;
`endif
                end else begin
                    ed = m_regs[idx];
                    eb = m_pend[idx];
                end
                anyb = anyb | eb;
                chk($sformatf("model_rd_data%0d", k), 64'(rd_data[k*DW +: DW]), 64'(ed));
                chk($sformatf("model_rd_busy%0d", k), 64'(rd_busy[k]), 64'(eb));
            end
            chk("model_any_busy", 64'(any_busy), 64'(anyb));
            cnt = 0;
            for (int r = 0; r < DP; r++) cnt += int'(m_pend[r]);
            chk("model_pend_cnt", 64'(pend_cnt), 64'(cnt));
        end
        if (reset) begin
            for (int r = 0; r < DP; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 0;
            end
            model_valid = 1;
        end else if (model_valid) begin
            if (write_en && reg_wr != 0) begin
                m_regs[reg_wr] = data;
                m_pend[reg_wr] = 0;
            end
            if (issue_en && issue_reg != 0) m_pend[issue_reg] = 1;
        end
    end

    initial begin
        reset = 1; write_en = 0; issue_en = 0;
        reg_wr = '0; data = '0; issue_reg = '0; rd_reg = '0;
        step(); step();
        idle();
        set_rd(0, 5); set_rd(1, 5);
        #1;
        chk("init_pend_cnt", 64'(pend_cnt), 64'd0);
        chk("init_rd_data0", 64'(rd_data[31:0]), 64'd0);
        $display("txn: initial reset");

        // Reset clears stored data
        write_en = 1; reg_wr = 5; data = 32'h0040_90FD;
        step(); idle();
        #1;
        chk("wr5_before_reset", 64'(rd_data[31:0]), 64'h0040_90FD);
        reset = 1;
        step(); idle();
        #1;
        chk("reset_rd0", 64'(rd_data[31:0]), 64'd0);
        chk("reset_rd1", 64'(rd_data[63:32]), 64'd0);
        chk("reset_pend_cnt", 64'(pend_cnt), 64'd0);
        $display("txn: reset after write to reg 5");

        // Write/read and zero register
        write_en = 1; reg_wr = 5; data = 32'd4231421;
        step(); idle();
        set_rd(0, 5); set_rd(1, 0);
        #1;
        chk("wr5_rd0", 64'(rd_data[31:0]), 64'd4231421);
        chk("zero_rd1", 64'(rd_data[63:32]), 64'd0);
        write_en = 1; reg_wr = 0; data = 32'd7;
        step(); idle();
        set_rd(0, 0);
        #1;
        chk("zero_wr_ignored", 64'(rd_data[31:0]), 64'd0);
        $display("txn: write/read reg 5, write reg 0");

        // Scoreboard
        issue_en = 1; issue_reg = 3;
        step();
        issue_reg = 9;
        step(); idle();
        set_rd(0, 3); set_rd(1, 9);
        #1;
        chk("sb_pend_cnt2", 64'(pend_cnt), 64'd2);
        chk("sb_busy", 64'(rd_busy), 64'b11);
        chk("sb_any_busy", 64'(any_busy), 64'd1);
        write_en = 1; reg_wr = 3; data = 32'h33;
        step(); idle();
        #1;
        chk("sb_busy3_clear", 64'(rd_busy[0]), 64'd0);
        chk("sb_pend_cnt1", 64'(pend_cnt), 64'd1);
        $display("txn: issue 3,9 then write 3");

        // Collision on reg 9
        issue_en = 1; issue_reg = 9; write_en = 1; reg_wr = 9; data = 32'hDEAD_BEEF;
        step(); idle();
        set_rd(0, 9);
        #1;
        chk("col_data", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("col_busy", 64'(rd_busy[0]), 64'd1);
        chk("col_pend_cnt", 64'(pend_cnt), 64'd1);
        $display("txn: issue+write collision on reg 9");

        // Same-cycle read of a register being written
        write_en = 1; reg_wr = 12; data = 32'h1234_5678; set_rd(1, 12);
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("byp_same_cycle", 64'(rd_data[63:32]), 64'h1234_5678);
        chk("byp_busy", 64'(rd_busy[1]), 64'd0);
`else
        chk("nobyp_same_cycle", 64'(rd_data[63:32]), 64'd0);
`endif
        step(); idle();
        #1;
        chk("byp_next_cycle", 64'(rd_data[63:32]), 64'h1234_5678);
        $display("txn: write reg 12 with concurrent read");

        // Reset mid-flight
        issue_en = 1; issue_reg = 1; step();
        issue_reg = 2; step();
        issue_reg = 4; step(); idle();
        #1;
        chk("mid_pend_cnt4", 64'(pend_cnt), 64'd4);
        reset = 1; step(); idle();
        #1;
        chk("mid_reset_cnt", 64'(pend_cnt), 64'd0);
        write_en = 1; reg_wr = 2; data = 32'd55;
        step(); idle();
        set_rd(0, 2);
        #1;
        chk("mid_wr2_data", 64'(rd_data[31:0]), 64'd55);
        chk("mid_wr2_busy", 64'(rd_busy[0]), 64'd0);
        $display("txn: reset with regs 1,2,4 in flight, then write reg 2");

        // Randomized traffic, checked every cycle by the model process
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            write_en  = $urandom_range(0, 1);
            reg_wr    = AW'($urandom_range(0, DP-1));
            data      = $urandom;
            issue_en  = ($urandom_range(0, 2) == 0);
            issue_reg = AW'($urandom_range(0, DP-1));
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 3) == 0) set_rd(k, int'(reg_wr));
                else set_rd(k, $urandom_range(0, DP-1));
            end
            step();
            $display("txn: rand %0d rst=%0d we=%0d wr=%0d iss=%0d ir=%0d rd=%0h", i, reset,
                     write_en, reg_wr, issue_en, issue_reg, rd_reg);
        end
        idle();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_sb.md
Name: regbank_sb

Overview:
- Parametrised successor to the 32x32 two-read/one-write register bank used by the RISC datapath.
- Generalised in data width, register count and read-port count.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards on in-flight results.
- Optional same-cycle write-to-read bypass.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- DATA_W, 32, width of each register in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register index width (derived; do not override).
- NUM_RD, 2, number of independent read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked pending.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- write_en  in  1  writeback strobe.
- reg_wr  in  ADDR_W  writeback destination index.
- data  in  DATA_W  writeback value.
- issue_en  in  1  decode issued an instruction that will write issue_reg.
- issue_reg  in  ADDR_W  destination index of the issued instruction.
- rd_reg  in  NUM_RD*ADDR_W  packed read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  bit k = pending flag of rd_reg[k].
- any_busy  out  1  OR of all rd_busy bits (stall request to decode).
- pend_cnt  out  ADDR_W+1  number of registers currently pending.

Behaviour:
- Storage: DEPTH x DATA_W array `regs` and DEPTH-bit vector `pend`, both updated only on the rising edge of clk.
- Reset: when reset=1 at a clk edge, all regs clear to 0, pend clears to 0 and pend_cnt clears to 0. reset overrides write_en and issue_en in that cycle.
  - Output values after the reset edge: rd_data=0, rd_busy=0, any_busy=0, pend_cnt=0.
  - A reset asserted mid-operation drops every in-flight pending flag. Later writebacks to those registers still write data and leave pend clear.
- Write: write_en=1 sets regs[reg_wr] <= data at the edge. Write latency is 1 cycle (visible on reads in the following cycle).
  - When ZERO_REG=1 and reg_wr=0, the write is discarded.
- Read: rd_data port k = regs[rd_reg[k]], combinational (0 cycles). Ports are fully independent; any number may address the same register.
  - When ZERO_REG=1 and rd_reg[k]=0, port k returns 0 and rd_busy[k]=0.
- Scoreboard, per register r at each edge (reset low):
  - issue_en and issue_reg==r -> pend[r] <= 1 (issue has priority).
  - otherwise write_en and reg_wr==r -> pend[r] <= 0.
  - otherwise pend[r] holds.
  - Simultaneous issue and write to the same r: pend[r] stays/becomes 1, because the new producer supersedes the completing one. The data write still occurs.
  - Issue to an already-pending register leaves it at 1; the count does not double.
  - Write to a non-pending register: data written, pend unchanged, no error.
  - ZERO_REG=1: issue to index 0 is ignored.
- rd_busy[k] = pend[rd_reg[k]], combinational from the registered pend.
- pend_cnt: registered population count of pend, updated on the same edge as pend and consistent with it in the same cycle. Range 0..DEPTH; no wrap is possible.
- No X on any output after the first reset edge. Out-of-range indices are impossible by construction because DEPTH is a power of two.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - A read port whose rd_reg[k] equals reg_wr while write_en=1 returns data in the same cycle.
  - rd_busy[k] for that port is forced to 0 unless issue_en also targets the same register in that cycle.
  - Zero-register rules still apply.
- Undefined: reads return the pre-edge stored value, and rd_busy reflects the stored pend only.

Test Plan:
- Reset: write regs 5=32'h0040_90FD, then assert reset 1 cycle -> rd_reg={5,5} reads 0/0, pend_cnt=0.
- Write/read: write_en=1, reg_wr=5, data=4231421; next cycle rd_reg port0=5 -> rd_data port0=4231421. Port1=0 (ZERO_REG) -> 0. Write to reg 0 value 7 -> still reads 0.
- Scoreboard: issue reg 3, then reg 9 -> pend_cnt=2 and rd_busy=1 for 3 and 9. Write reg 3 -> rd_busy(3)=0, pend_cnt=1.
- Collision: with reg 9 pending, issue_en and write_en both to 9 in the same cycle, data=32'hDEAD_BEEF -> reg 9 reads DEADBEEF, rd_busy(9)=1, pend_cnt unchanged at 1.
- Bypass (REGBANK_BYPASS_EN): write reg 12=32'h1234_5678 while rd_reg port1=12 -> port1 shows 12345678 and rd_busy(1)=0 in the same cycle. Without the macro -> old value, and 12345678 appears the next cycle.
- Reset mid-flight: issue regs 1,2,4, then assert reset -> pend_cnt=0. Later write to reg 2 value 55 -> reads 55, rd_busy=0.
